// File: rtl/fpu_fflags_accum.sv
// Per-warp sticky FP exception flags and rounding-mode store.
// Flags from FPU commits are OR-reduced over active threads and merged one cycle later; CSR reads bypass the pending update.
module fpu_fflags_accum #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int WID_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fpu_valid,
  output logic                     fpu_ready,
  input  logic [WID_BITS-1:0]      fpu_wid,
  input  logic [NUM_THREADS-1:0]   fpu_tmask,
  input  logic                     fpu_has_fflags,
  input  logic [NUM_THREADS*5-1:0] fpu_fflags,
  input  logic                     csr_write_valid,
  input  logic [WID_BITS-1:0]      csr_write_wid,
  input  logic [1:0]               csr_write_addr,
  input  logic [7:0]               csr_write_data,
  input  logic [WID_BITS-1:0]      csr_read_wid,
  input  logic [1:0]               csr_read_addr,
  output logic [7:0]               csr_read_data,
  input  logic [WID_BITS-1:0]      frm_wid,
  output logic [2:0]               frm
);

  typedef enum logic [1:0] {
    CSR_FFLAGS = 2'd0,
    CSR_FRM    = 2'd1,
    CSR_FCSR   = 2'd2,
    CSR_RSVD   = 2'd3
  } csr_addr_e;

  // {NV, DZ, OF, UF, NX}
  typedef logic [4:0] fflags_t;

  fflags_t             fflags_q [NUM_WARPS];
  logic [2:0]          frm_q    [NUM_WARPS];

  logic                pend_valid;
  logic [WID_BITS-1:0] pend_wid;
  fflags_t             pend_flags;

  logic                accept;
  fflags_t             red_flags;
  logic                wr_fflags;
  logic                wr_frm;
  fflags_t             wr_fflags_data;
  logic [2:0]          wr_frm_data;

  // A CSR write and a new commit never share a cycle, so the write never races a stage-1 accept.
  assign fpu_ready = !reset && !csr_write_valid;
  assign accept    = fpu_valid && fpu_ready && fpu_has_fflags;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    red_flags = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (fpu_tmask[t]) red_flags = red_flags | fpu_fflags[5*t +: 5];
    end
  end

  always_comb begin
    wr_fflags      = 1'b0;
    wr_frm         = 1'b0;
    wr_fflags_data = csr_write_data[4:0];
    wr_frm_data    = csr_write_data[2:0];
    if (csr_write_valid) begin
      case (csr_addr_e'(csr_write_addr))
        CSR_FFLAGS: wr_fflags = 1'b1;
        CSR_FRM:    wr_frm    = 1'b1;
        CSR_FCSR: begin
          wr_fflags   = 1'b1;
          wr_frm      = 1'b1;
          wr_frm_data = csr_write_data[7:5];
        end
        default: ;
      endcase
    end
  end

  // NOTE: the flag and frm arrays are a handful of flops, not a RAM, so they take the reset like any other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_wid   <= '0;
      pend_flags <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        fflags_q[w] <= '0;
        frm_q[w]    <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout; a later <= to the same flop overrides an earlier one.
      pend_valid <= accept;
      if (accept) begin
        pend_wid   <= fpu_wid;
        pend_flags <= red_flags;
      end
      for (int w = 0; w < NUM_WARPS; w++) begin
        // The pending OR is older than the CSR write, so the write lands last and wins.
        if (pend_valid && pend_wid == WID_BITS'(w))
          fflags_q[w] <= fflags_q[w] | pend_flags;
        if (wr_fflags && csr_write_wid == WID_BITS'(w))
          fflags_q[w] <= wr_fflags_data;
        if (wr_frm && csr_write_wid == WID_BITS'(w))
          frm_q[w] <= wr_frm_data;
      end
    end
  end

  fflags_t    rd_fflags;
  logic [2:0] rd_frm;

  always_comb begin
    rd_fflags = fflags_q[csr_read_wid];
    if (pend_valid && pend_wid == csr_read_wid) rd_fflags = rd_fflags | pend_flags;
    rd_frm = frm_q[csr_read_wid];
    case (csr_addr_e'(csr_read_addr))
      CSR_FFLAGS: csr_read_data = {3'b000, rd_fflags};
      CSR_FRM:    csr_read_data = {5'b00000, rd_frm};
      CSR_FCSR:   csr_read_data = {rd_frm, rd_fflags};
      default:    csr_read_data = 8'h00;
    endcase
  end

  assign frm = frm_q[frm_wid];

endmodule

// File: tb/tb_fpu_fflags_accum.sv
// Directed bench for fpu_fflags_accum: hand-computed flag/frm values for
// commits, CSR writes, same-cycle ordering, back-pressure and reset.
module tb_fpu_fflags_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [1:0]  fpu_wid;
  logic [3:0]  fpu_tmask;
  logic        fpu_has_fflags;
  logic [19:0] fpu_fflags;
  logic        csr_write_valid;
  logic [1:0]  csr_write_wid;
  logic [1:0]  csr_write_addr;
  logic [7:0]  csr_write_data;
  logic [1:0]  csr_read_wid;
  logic [1:0]  csr_read_addr;
  logic [7:0]  csr_read_data;
  logic [1:0]  frm_wid;
  logic [2:0]  frm;

  int checks = 0;
  int errors = 0;

  fpu_fflags_accum dut (
    .clk             (clk),
    .reset           (reset),
    .fpu_valid       (fpu_valid),
    .fpu_ready       (fpu_ready),
    .fpu_wid         (fpu_wid),
    .fpu_tmask       (fpu_tmask),
    .fpu_has_fflags  (fpu_has_fflags),
    .fpu_fflags      (fpu_fflags),
    .csr_write_valid (csr_write_valid),
    .csr_write_wid   (csr_write_wid),
    .csr_write_addr  (csr_write_addr),
    .csr_write_data  (csr_write_data),
    .csr_read_wid    (csr_read_wid),
    .csr_read_addr   (csr_read_addr),
    .csr_read_data   (csr_read_data),
    .frm_wid         (frm_wid),
    .frm             (frm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [1:0] wid, input logic [1:0] addr, input logic [7:0] exp);
    csr_read_wid  = wid;
    csr_read_addr = addr;
    #1;
    check(tag, csr_read_data, exp);
  endtask

  task automatic chk_frm(input string tag, input logic [1:0] wid, input logic [2:0] exp);
    frm_wid = wid;
    #1;
    check(tag, {5'b0, frm}, {5'b0, exp});
  endtask

  task automatic commit(input logic [1:0] wid, input logic [3:0] tmask, input logic has, input logic [19:0] flags);
    fpu_valid      = 1'b1;
    fpu_wid        = wid;
    fpu_tmask      = tmask;
    fpu_has_fflags = has;
    fpu_fflags     = flags;
  endtask

  task automatic idle();
    fpu_valid       = 1'b0;
    fpu_has_fflags  = 1'b0;
    fpu_tmask       = '0;
    fpu_fflags      = '0;
    csr_write_valid = 1'b0;
  endtask

  task automatic csr_wr(input logic [1:0] wid, input logic [1:0] addr, input logic [7:0] data);
    csr_write_valid = 1'b1;
    csr_write_wid   = wid;
    csr_write_addr  = addr;
    csr_write_data  = data;
  endtask

  logic [4:0] bp_vec [3] = '{5'h01, 5'h02, 5'h08};

  initial begin
    int  cyc;
    int  idx;
    int  hs;
    logic hs_now;

    reset = 1'b1;
    idle();
    fpu_wid = '0; csr_write_wid = '0; csr_write_addr = '0; csr_write_data = '0;
    csr_read_wid = '0; csr_read_addr = '0; frm_wid = '0;

    // Reset: ready low even with a commit offered; state reads as zero.
    commit(2'd0, 4'hF, 1'b1, 20'hFFFFF);
    #1;
    check("ready_in_reset", {7'b0, fpu_ready}, 8'h00);
    tick();
    check("ready_in_reset_edge", {7'b0, fpu_ready}, 8'h00);
    tick();
    rd("rst_fcsr_w0", 2'd0, 2'd2, 8'h00);
    rd("rst_fcsr_w1", 2'd1, 2'd2, 8'h00);
    rd("rst_fcsr_w2", 2'd2, 2'd2, 8'h00);
    rd("rst_fcsr_w3", 2'd3, 2'd2, 8'h00);
    chk_frm("rst_frm_w0", 2'd0, 3'd0);
    idle();
    reset = 1'b0;
    tick();
    check("ready_after_reset", {7'b0, fpu_ready}, 8'h01);
    rd("post_rst_w0", 2'd0, 2'd2, 8'h00);

    // Masked reduction: threads 0 and 2 active -> NX|OF = 0x05.
    commit(2'd1, 4'b0101, 1'b1, {5'h1F, 5'h04, 5'h10, 5'h01});
    tick();
    idle();
    rd("mask_bypass_w1", 2'd1, 2'd0, 8'h05);
    rd("mask_other_w0", 2'd0, 2'd0, 8'h00);
    tick();
    rd("mask_array_w1", 2'd1, 2'd0, 8'h05);

    // frm write, then back-to-back DZ and UF on wid 2.
    csr_wr(2'd2, 2'd1, 8'h03);
    tick();
    idle();
    chk_frm("frm_w2", 2'd2, 3'd3);
    commit(2'd2, 4'b0001, 1'b1, 20'h00008);
    tick();
    commit(2'd2, 4'b0001, 1'b1, 20'h00002);
    tick();
    idle();
    rd("b2b_fflags_w2", 2'd2, 2'd0, 8'h0A);
    rd("b2b_fcsr_w2", 2'd2, 2'd2, 8'h6A);
    rd("b2b_frm_w2", 2'd2, 2'd1, 8'h03);
    tick();
    rd("b2b_fcsr_w2_settled", 2'd2, 2'd2, 8'h6A);

    // Pending NV on wid 0 meets an fflags write of 0: the write wins.
    commit(2'd0, 4'b0001, 1'b1, 20'h00010);
    tick();
    idle();
    csr_wr(2'd0, 2'd0, 8'h00);
    rd("wr_same_cycle_view", 2'd0, 2'd0, 8'h10);
    tick();
    idle();
    rd("wr_discards_pend", 2'd0, 2'd0, 8'h00);
    tick();
    rd("wr_discards_settled", 2'd0, 2'd0, 8'h00);

    // Same again with an frm-only write of 5: the OR survives.
    commit(2'd0, 4'b0001, 1'b1, 20'h00010);
    tick();
    idle();
    csr_wr(2'd0, 2'd1, 8'h05);
    tick();
    idle();
    rd("frm_keeps_or", 2'd0, 2'd0, 8'h10);
    rd("frm_keeps_fcsr", 2'd0, 2'd2, 8'hB0);
    chk_frm("frm_w0", 2'd0, 3'd5);

    // Pending OF on wid 3 while fflags of wid 1 is written: independent.
    commit(2'd3, 4'b0001, 1'b1, 20'h00004);
    tick();
    idle();
    csr_wr(2'd1, 2'd0, 8'h1F);
    tick();
    idle();
    rd("indep_w3", 2'd3, 2'd0, 8'h04);
    rd("indep_w1", 2'd1, 2'd0, 8'h1F);

    // Clear wid 3 via fcsr (frm 0), then stream 3 commits with a CSR pulse in cycle 1.
    csr_wr(2'd3, 2'd2, 8'h00);
    tick();
    idle();
    rd("clear_w3", 2'd3, 2'd2, 8'h00);
    cyc = 0; idx = 0; hs = 0;
    while (idx < 3 && cyc < 10) begin
      commit(2'd3, 4'b0001, 1'b1, {15'b0, bp_vec[idx]});
      if (cyc == 1) csr_wr(2'd1, 2'd1, 8'h02);
      else csr_write_valid = 1'b0;
      #1;
      check($sformatf("bp_ready_c%0d", cyc), {7'b0, fpu_ready}, (cyc == 1) ? 8'h00 : 8'h01);
      hs_now = fpu_valid && fpu_ready;
      tick();
      if (hs_now) begin
        hs++;
        idx++;
      end
      cyc++;
    end
    idle();
    check("bp_handshakes", 8'(hs), 8'd3);
    check("bp_cycles", 8'(cyc), 8'd4);
    tick();
    rd("bp_result_w3", 2'd3, 2'd0, 8'h0B);
    chk_frm("bp_frm_w1", 2'd1, 3'd2);

    // has_fflags=0 and all-zero tmask are accepted and change nothing.
    commit(2'd0, 4'hF, 1'b0, 20'hFFFFF);
    #1;
    check("nofl_ready", {7'b0, fpu_ready}, 8'h01);
    tick();
    commit(2'd2, 4'h0, 1'b1, 20'hFFFFF);
    tick();
    idle();
    rd("nofl_w0", 2'd0, 2'd0, 8'h10);
    rd("zmask_w2", 2'd2, 2'd0, 8'h0A);
    tick();
    rd("nofl_w0_settled", 2'd0, 2'd0, 8'h10);
    rd("zmask_w2_settled", 2'd2, 2'd0, 8'h0A);

    // Reset with a pending update: everything reads zero afterwards.
    commit(2'd1, 4'b0001, 1'b1, 20'h00001);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    rd("rst_pend_w0", 2'd0, 2'd2, 8'h00);
    rd("rst_pend_w1", 2'd1, 2'd2, 8'h00);
    rd("rst_pend_w2", 2'd2, 2'd2, 8'h00);
    rd("rst_pend_w3", 2'd3, 2'd2, 8'h00);
    rd("rst_pend_rsvd", 2'd1, 2'd3, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
